// File: rtl/vae_fx_pkg.sv
// Q8.8 fixed-point constants, FSM state type and saturating add/sub helpers
// shared by the VAE backward-pass blocks.
package vae_fx_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;

    localparam logic [DW-1:0] FX_MAX = 16'h7FFF;
    localparam logic [DW-1:0] FX_MIN = 16'h8000;
    localparam logic [DW-1:0] FX_ONE = 16'h0100;

    typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1]) r = s[DW] ? FX_MIN : FX_MAX;
        else                  r = s[DW-1:0];
        return r;
    endfunction

    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        s = {a[DW-1], a} - {b[DW-1], b};
        if (s[DW] != s[DW-1]) r = s[DW] ? FX_MIN : FX_MAX;
        else                  r = s[DW-1:0];
        return r;
    endfunction

endpackage

// File: rtl/fx_sat_mult.sv
// Combinational Q8.8 x Q8.8 multiply: truncate toward -inf, saturate to Q8.8 range.
module fx_sat_mult
    import vae_fx_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] p
);

    logic signed [2*DW-1:0] full;
    logic signed [2*DW-1:0] shifted;

    assign full    = $signed(a) * $signed(b);
    assign shifted = full >>> FRAC;

    // Result fits only if everything above the kept field is a copy of the sign.
    always_comb begin
        if (shifted[2*DW-1:DW-1] == {(DW+1){shifted[2*DW-1]}}) p = shifted[DW-1:0];
        else                                                  p = shifted[2*DW-1] ? FX_MIN : FX_MAX;
    end

endmodule

// File: rtl/vae_backward_out_layer.sv
// Sequential backward pass for the 2->N_OUT decoder output layer: one shared
// multiplier, seven multiplies per neuron, streamed weight/bias updates.
module vae_backward_out_layer
    import vae_fx_pkg::*;
#(
    parameter int N_OUT = 9
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DW-1:0]           lr,
    input  logic [DW-1:0]           a1,
    input  logic [DW-1:0]           a2,
    input  logic [N_OUT*DW-1:0]     out_vec,
    input  logic [N_OUT*DW-1:0]     tgt_vec,
    input  logic [2*N_OUT*DW-1:0]   w_vec,
    input  logic [N_OUT*DW-1:0]     b_vec,
    output logic                    busy,
    output logic                    upd_valid,
    output logic [3:0]              upd_idx,
    output logic [DW-1:0]           upd_w1,
    output logic [DW-1:0]           upd_w2,
    output logic [DW-1:0]           upd_b,
    output logic [DW-1:0]           err_a1,
    output logic [DW-1:0]           err_a2,
    output logic                    done
);

    state_t state_reg, state_next;
    logic [3:0] idx_reg;
    logic [2:0] op_reg;

    logic [DW-1:0]         lr_reg, a1_reg, a2_reg;
    logic [N_OUT*DW-1:0]   out_reg, tgt_reg, b_reg;
    logic [2*N_OUT*DW-1:0] w_reg;

    logic [DW-1:0] delta_reg, gw1_reg, gw2_reg, t1_reg, t2_reg, tb_reg;
    logic [DW-1:0] err_a1_reg, err_a2_reg;
    logic [DW-1:0] upd_w1_reg, upd_w2_reg, upd_b_reg;
    logic [3:0]    upd_idx_reg;

    logic [DW-1:0] out_arr [N_OUT];
    logic [DW-1:0] tgt_arr [N_OUT];
    logic [DW-1:0] w1_arr  [N_OUT];
    logic [DW-1:0] w2_arr  [N_OUT];
    logic [DW-1:0] b_arr   [N_OUT];

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_unpack
        assign out_arr[gi] = out_reg[gi*DW +: DW];
        assign tgt_arr[gi] = tgt_reg[gi*DW +: DW];
        assign w1_arr[gi]  = w_reg[(2*gi)*DW +: DW];
        assign w2_arr[gi]  = w_reg[(2*gi+1)*DW +: DW];
        assign b_arr[gi]   = b_reg[gi*DW +: DW];
    end

    logic          start_ok;
    logic          last_idx;
    logic [DW-1:0] delta_comb, mult_a, mult_b, prod;

    assign start_ok   = start && (state_reg == IDLE || state_reg == DONE);
    assign last_idx   = (idx_reg == 4'(N_OUT-1));
    assign delta_comb = sat_sub(out_arr[idx_reg], tgt_arr[idx_reg]);

    // op0 uses the freshly computed delta; later ops reuse the registered copy.
    always_comb begin
        mult_a = '0;
        mult_b = '0;
        case (op_reg)
            3'd0: begin mult_a = delta_comb; mult_b = a1_reg;           end
            3'd1: begin mult_a = delta_reg;  mult_b = a2_reg;           end
            3'd2: begin mult_a = lr_reg;     mult_b = gw1_reg;          end
            3'd3: begin mult_a = lr_reg;     mult_b = gw2_reg;          end
            3'd4: begin mult_a = lr_reg;     mult_b = delta_reg;        end
            3'd5: begin mult_a = delta_reg;  mult_b = w1_arr[idx_reg];  end
            3'd6: begin mult_a = delta_reg;  mult_b = w2_arr[idx_reg];  end
            default: ;
        endcase
    end

    fx_sat_mult u_mult (
        .a (mult_a),
        .b (mult_b),
        .p (prod)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (op_reg == 3'd6) state_next = WRITE;
            WRITE:   state_next = last_idx ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            op_reg      <= '0;
            lr_reg      <= '0;
            a1_reg      <= '0;
            a2_reg      <= '0;
            out_reg     <= '0;
            tgt_reg     <= '0;
            b_reg       <= '0;
            w_reg       <= '0;
            delta_reg   <= '0;
            gw1_reg     <= '0;
            gw2_reg     <= '0;
            t1_reg      <= '0;
            t2_reg      <= '0;
            tb_reg      <= '0;
            err_a1_reg  <= '0;
            err_a2_reg  <= '0;
            upd_w1_reg  <= '0;
            upd_w2_reg  <= '0;
            upd_b_reg   <= '0;
            upd_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                lr_reg     <= lr;
                a1_reg     <= a1;
                a2_reg     <= a2;
                out_reg    <= out_vec;
                tgt_reg    <= tgt_vec;
                w_reg      <= w_vec;
                b_reg      <= b_vec;
                err_a1_reg <= '0;
                err_a2_reg <= '0;
                idx_reg    <= '0;
                op_reg     <= '0;
            end else if (state_reg == RUN) begin
                op_reg <= (op_reg == 3'd6) ? 3'd0 : op_reg + 3'd1;
                case (op_reg)
                    3'd0: begin delta_reg <= delta_comb; gw1_reg <= prod; end
                    3'd1: gw2_reg <= prod;
                    3'd2: t1_reg  <= prod;
                    3'd3: t2_reg  <= prod;
                    3'd4: tb_reg  <= prod;
                    3'd5: err_a1_reg <= sat_add(err_a1_reg, prod);
                    3'd6: begin
                        // Updates land with the WRITE cycle; err uses the old weights.
                        err_a2_reg  <= sat_add(err_a2_reg, prod);
                        upd_idx_reg <= idx_reg;
                        upd_w1_reg  <= sat_sub(w1_arr[idx_reg], t1_reg);
                        upd_w2_reg  <= sat_sub(w2_arr[idx_reg], t2_reg);
                        upd_b_reg   <= sat_sub(b_arr[idx_reg], tb_reg);
                    end
                    default: ;
                endcase
            end else if (state_reg == WRITE && !last_idx) begin
                idx_reg <= idx_reg + 4'd1;
            end
        end
    end

    assign busy      = (state_reg == RUN) || (state_reg == WRITE);
    assign upd_valid = (state_reg == WRITE);
    assign done      = (state_reg == DONE);
    assign upd_idx   = upd_idx_reg;
    assign upd_w1    = upd_w1_reg;
    assign upd_w2    = upd_w2_reg;
    assign upd_b     = upd_b_reg;
    assign err_a1    = err_a1_reg;
    assign err_a2    = err_a2_reg;

endmodule

// File: tb/tb_vae_backward_out_layer.sv
// Directed self-checking bench for vae_backward_out_layer: zero-error run,
// single-neuron update, saturation, start-while-busy, mid-run reset, back-to-back.
module tb_vae_backward_out_layer;

    localparam int N  = 9;
    localparam int DW = 16;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              start = 1'b0;
    logic [DW-1:0]     lr, a1, a2;
    logic [N*DW-1:0]   out_vec, tgt_vec, b_vec;
    logic [2*N*DW-1:0] w_vec;
    logic              busy, upd_valid, done;
    logic [3:0]        upd_idx;
    logic [DW-1:0]     upd_w1, upd_w2, upd_b, err_a1, err_a2;

    vae_backward_out_layer #(.N_OUT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lr        (lr),
        .a1        (a1),
        .a2        (a2),
        .out_vec   (out_vec),
        .tgt_vec   (tgt_vec),
        .w_vec     (w_vec),
        .b_vec     (b_vec),
        .busy      (busy),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_w1    (upd_w1),
        .upd_w2    (upd_w2),
        .upd_b     (upd_b),
        .err_a1    (err_a1),
        .err_a2    (err_a2),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int t0     = 0;

    // Stimulus and expected results
    logic [DW-1:0] o_a [N], t_a [N], w1_a [N], w2_a [N], b_a [N];
    logic [DW-1:0] e_w1 [N], e_w2 [N], e_b [N];
    logic [DW-1:0] lr_v, a1_v, a2_v, e_e1, e_e2;

    // Observed transactions
    int            s_idx [$];
    int            s_cyc [$];
    logic [DW-1:0] s_w1 [$], s_w2 [$], s_b [$];
    int            d_cyc [$];
    logic [DW-1:0] d_e1 [$], d_e2 [$];
    int            busy_n, busy_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (upd_valid) begin
                s_idx.push_back(int'(upd_idx));
                s_cyc.push_back(cyc - t0);
                s_w1.push_back(upd_w1);
                s_w2.push_back(upd_w2);
                s_b.push_back(upd_b);
            end
            if (done) begin
                d_cyc.push_back(cyc - t0);
                d_e1.push_back(err_a1);
                d_e2.push_back(err_a2);
            end
            if (busy) begin
                if (busy_n == 0) busy_first = cyc - t0;
                busy_n++;
            end
        end
    endtask

    task automatic clear_obs();
        s_idx.delete(); s_cyc.delete(); s_w1.delete(); s_w2.delete(); s_b.delete();
        d_cyc.delete(); d_e1.delete(); d_e2.delete();
        busy_n = 0;
        busy_first = -1;
    endtask

    task automatic apply();
        lr = lr_v; a1 = a1_v; a2 = a2_v;
        for (int i = 0; i < N; i++) begin
            out_vec[i*DW +: DW]       = o_a[i];
            tgt_vec[i*DW +: DW]       = t_a[i];
            w_vec[(2*i)*DW +: DW]     = w1_a[i];
            w_vec[(2*i+1)*DW +: DW]   = w2_a[i];
            b_vec[i*DW +: DW]         = b_a[i];
        end
    endtask

    // out == tgt everywhere: every delta is zero, so updates echo the inputs.
    task automatic load_zero();
        lr_v = 16'h0100; a1_v = 16'h0123; a2_v = 16'hFF00;
        for (int i = 0; i < N; i++) begin
            o_a[i]  = 16'(i*300 - 1000);
            t_a[i]  = o_a[i];
            w1_a[i] = 16'(i*257 + 5);
            w2_a[i] = 16'(32'h8000 + i*3);
            b_a[i]  = 16'(32'hF000 + i*77);
            e_w1[i] = w1_a[i];
            e_w2[i] = w2_a[i];
            e_b[i]  = b_a[i];
        end
        e_e1 = 16'h0000; e_e2 = 16'h0000;
    endtask

    task automatic load_single();
        load_zero();
        lr_v = 16'h0080; a1_v = 16'h0080; a2_v = 16'h0100;
        o_a[0] = 16'h0200; t_a[0] = 16'h0100;
        w1_a[0] = 16'h0100; w2_a[0] = 16'h0200; b_a[0] = 16'h0000;
        e_w1[0] = 16'h00C0; e_w2[0] = 16'h0180; e_b[0] = 16'hFF80;
        e_e1 = 16'h0100; e_e2 = 16'h0200;
    endtask

    // delta saturates to 0x7FFF; 0x7FFF*0x7FFF saturates; 0x8000-0x7FFF clamps.
    task automatic load_sat();
        load_zero();
        lr_v = 16'h0100; a1_v = 16'h7FFF; a2_v = 16'h0000;
        o_a[0] = 16'h7F00; t_a[0] = 16'h8100;
        w1_a[0] = 16'h8000; w2_a[0] = 16'h0000; b_a[0] = 16'h0000;
        e_w1[0] = 16'h8000; e_w2[0] = 16'h0000; e_b[0] = 16'h8001;
        e_e1 = 16'h8000; e_e2 = 16'h0000;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc - 1;
    endtask

    // Waits for done (+2 cycles) or the limit; optional extra starts and a reset pulse.
    task automatic wait_run(input int limit, input int p1, input int p2, input int rst_at);
        int cur;
        cur = 0;
        while (cur < limit) begin
            @(negedge clk);
            #1;
            cur = cyc - t0;
            if (d_cyc.size() > 0 && cur >= d_cyc[0] + 2) break;
            start = (cur == p1) || (cur == p2);
            if (start) begin
                lr = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
                for (int i = 0; i < N; i++) begin
                    out_vec[i*DW +: DW] = 16'($urandom);
                    w_vec[(2*i)*DW +: DW] = 16'($urandom);
                end
            end
            if (rst_at > 0 && cur == rst_at) begin
                rst = 1'b0;
                #1;
                check("rst.busy", busy, 0);
                check("rst.upd_valid", upd_valid, 0);
                check("rst.done", done, 0);
                check("rst.upd_w1", upd_w1, 0);
                check("rst.upd_w2", upd_w2, 0);
                check("rst.upd_b", upd_b, 0);
                check("rst.upd_idx", upd_idx, 0);
                check("rst.err_a1", err_a1, 0);
            end
            if (rst_at > 0 && cur == rst_at + 2) rst = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int base);
        check({tag, ".n_upd"}, s_idx.size(), N);
        for (int k = 0; k < s_idx.size() && k < N; k++) begin
            check($sformatf("%s.idx%0d", tag, k), s_idx[k], k);
            check($sformatf("%s.cyc%0d", tag, k), s_cyc[k], base + 8*k + 8);
            check($sformatf("%s.w1_%0d", tag, k), s_w1[k], e_w1[k]);
            check($sformatf("%s.w2_%0d", tag, k), s_w2[k], e_w2[k]);
            check($sformatf("%s.b_%0d", tag, k), s_b[k], e_b[k]);
        end
        check({tag, ".n_done"}, d_cyc.size(), 1);
        if (d_cyc.size() > 0) begin
            check({tag, ".done_cyc"}, d_cyc[0], base + 8*N + 1);
            check({tag, ".err_a1"}, d_e1[0], e_e1);
            check({tag, ".err_a2"}, d_e2[0], e_e2);
            $display("run %s: strobes=%0d done_cyc=%0d err_a1=%h err_a2=%h",
                     tag, s_idx.size(), d_cyc[0], d_e1[0], d_e2[0]);
        end else begin
            $display("run %s: strobes=%0d no done seen", tag, s_idx.size());
        end
    endtask

    initial begin
        int  cur;
        bit  hit;
        clear_obs();
        load_zero();
        apply();
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", busy, 0);
        check("reset.upd_valid", upd_valid, 0);
        check("reset.done", done, 0);
        check("reset.upd_w1", upd_w1, 0);
        check("reset.err_a1", err_a1, 0);
        check("reset.err_a2", err_a2, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: all-zero deltas
        clear_obs(); load_zero(); apply(); do_start();
        wait_run(200, -1, -1, -1);
        check_run("zero", 0);
        check("zero.busy_cycles", busy_n, 72);
        check("zero.busy_first", busy_first, 1);

        // 2: single-neuron update
        clear_obs(); load_single(); apply(); do_start();
        wait_run(200, -1, -1, -1);
        check_run("single", 0);

        // 3: saturation
        clear_obs(); load_sat(); apply(); do_start();
        wait_run(200, -1, -1, -1);
        check_run("sat", 0);

        // 4: start pulses while busy, inputs scrambled after acceptance
        clear_obs(); load_single(); apply(); do_start();
        wait_run(200, 5, 40, -1);
        check_run("busy_start", 0);

        // 5: reset mid-run, then a fresh run must match scenario 2
        clear_obs(); load_single(); apply(); do_start();
        wait_run(130, -1, -1, 30);
        check("rst.n_upd", s_idx.size(), 3);
        check("rst.n_done", d_cyc.size(), 0);
        $display("run reset_mid: strobes=%0d done_pulses=%0d", s_idx.size(), d_cyc.size());
        clear_obs(); load_single(); apply(); do_start();
        wait_run(200, -1, -1, -1);
        check_run("after_rst", 0);

        // 6: back-to-back, second start in the done cycle
        clear_obs(); load_single(); apply(); do_start();
        cur = 0;
        hit = 1'b0;
        while (!hit && cur < 120) begin
            @(negedge clk);
            #1;
            cur = cyc - t0;
            if (done) hit = 1'b1;
        end
        check("b2b.first_done_cyc", cur, 73);
        check("b2b.err_a1_held", err_a1, 16'h0100);
        check("b2b.err_a2_held", err_a2, 16'h0200);
        check_run("b2b_run1", 0);
        clear_obs(); load_sat(); apply();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b.err_a1_clr", err_a1, 0);
        check("b2b.err_a2_clr", err_a2, 0);
        check("b2b.busy", busy, 1);
        wait_run(200, -1, -1, -1);
        check_run("b2b_run2", 73);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
